alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station directly upstream of the ALU in the out-of-order core.
- Buffers decoded integer ops until both source operands are known.
- Captures operand values from the common data bus (CDB).
- Dispatches at most one ready op per cycle to the ALU as a registered bundle.

Parameters:
DEPTH, 8, number of station entries (2..16)
OP_W, 6, width of opType encoding (shared with ALU)
DATA_W, 32, operand/imm/PC width
TAG_W, 4, ROB tag width

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global enable; when low, all state holds and dispatch is suppressed
clear_in  input  1  flush on mispredict; synchronous, empties station
in_valid  input  1  decoder presents one op this cycle
in_op  input  OP_W  opType
in_vj, in_vk  input  DATA_W  operand values, valid when the matching busy flag is 0
in_qj_busy, in_qk_busy  input  1  operand pending on a ROB tag
in_qj, in_qk  input  TAG_W  producing ROB tag
in_imm  input  DATA_W  immediate
in_pc  input  DATA_W  instruction PC
in_rob  input  TAG_W  destination ROB tag
full  output  1  no free entry (combinational from busy bits)
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_W  broadcasting ROB tag
cdb_value  input  DATA_W  broadcast result
alu_valid  output  1  one-cycle pulse, bundle valid
alu_op  output  OP_W  opType to ALU
alu_rs1, alu_rs2  output  DATA_W  resolved operands
alu_pc, alu_imm  output  DATA_W  PC and immediate
alu_rob  output  TAG_W  destination tag

Behaviour:
- Reset (rst_in=0, async): all busy bits 0, alu_valid=0, all alu_* data outputs 0, full=0.
- Entry fields: busy, op, vj, vk, qj_busy, qk_busy, qj, qk, imm, pc, rob.
- Insert: when rdy_in & in_valid & !full & !clear_in, write to the lowest-index non-busy entry at the clock edge.
  - Free-slot selection uses pre-edge busy bits; a slot freed by dispatch this cycle is not reused until next cycle.
  - in_valid while full: op dropped, state unchanged; bench flags this as a protocol error.
- Wakeup: when cdb_valid, every busy entry with qj_busy & qj==cdb_tag sets vj=cdb_value and clears qj_busy; same rule for k.
- Bypass on insert: an incoming op whose in_qj/in_qk matches a same-cycle CDB tag is stored already resolved.
- Ready: busy & !qj_busy & !qk_busy, evaluated on registered state. An entry woken this cycle becomes eligible next cycle.
- Dispatch: if rdy_in & !clear_in and any entry is ready:
  - Lowest ready index wins.
  - At the edge, alu_* load that entry, alu_valid=1, and the entry's busy clears.
  - Otherwise alu_valid=0 and the alu_* data outputs hold.
  - Latency: insert with both operands ready at edge N gives alu_valid high after edge N+1.
- Simultaneous insert, wakeup and dispatch in one cycle: all apply independently to their entries.
- clear_in (with rdy_in=1): all busy bits 0 and alu_valid=0 at the next edge; concurrent insert and dispatch are discarded.
- rdy_in=0: no insert, wakeup, dispatch or clear is applied; alu_valid forced 0 at the next edge. CDB broadcasts during this time are lost; upstream holds the CDB while rdy_in is low.
- Tag comparison is exact over TAG_W bits; no wraparound semantics.

Decomposition:
- Shared package/header: OP_W, DATA_W, TAG_W, opType codes (OP_ADD, OP_SUB, OP_BNE, ...), TRUE/FALSE. All shared with the ALU and ROB.
- One sub-module, rs_prio_enc: a parameterised lowest-index priority encoder, instanced twice (free slot, ready slot), outputs index plus found flag.

Test Plan:
- Reset mid-operation: 3 entries busy, drop rst_in asynchronously -> full=0, alu_valid=0 immediately, no dispatch after release.
- Ready insert: in_op=OP_ADD, vj=5, vk=7, both busy=0, in_rob=3 at edge N -> alu_valid pulse after N+1 with rs1=5, rs2=7, alu_rob=3.
- Wakeup: insert with qj_busy=1, qj=9, vk=2; 2 cycles later CDB tag=9 value=0x10 -> dispatch the cycle after with rs1=0x10, rs2=2.
- Insert bypass: insert qk=4 in the same cycle as CDB tag=4 value=0xAB -> entry dispatches next cycle with rs2=0xAB.
- Full: insert DEPTH ops dependent on tag 1 -> full=1 and a further insert is ignored; CDB tag=1 -> one dispatch per cycle in index order 0..DEPTH-1, full drops after the first.
- Flush: 4 pending ops, then clear_in=1 together with in_valid=1 -> no dispatch follows, station empty, the new op is not stored; a later insert lands in entry 0.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the integer ALU path: widths, opType codes and booleans
// used by the reservation station, ALU and ROB.
package alu_rs_pkg;

    localparam int OP_W   = 6;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 6'd0,
        OP_SUB = 6'd1,
        OP_AND = 6'd2,
        OP_OR  = 6'd3,
        OP_XOR = 6'd4,
        OP_SLL = 6'd5,
        OP_SRL = 6'd6,
        OP_SRA = 6'd7,
        OP_SLT = 6'd8,
        OP_BEQ = 6'd9,
        OP_BNE = 6'd10
    } op_type_e;

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-index priority encoder: returns the index of the lowest set request bit
// and whether any bit was set.
module rs_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan from the top down so the lowest set bit is the last one to overwrite
    always_comb begin
        o_idx   = '0;
        o_found = |i_req;
        for (int i = N - 1; i >= 0; i--) begin
            o_idx = i_req[i] ? IDX_W'(i) : o_idx;
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Integer reservation station feeding the ALU: buffers ops until both operands
// resolve (from decode or the CDB) and issues the lowest ready entry each cycle.
module alu_rs #(
    parameter int DEPTH  = 8,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_vj,
    input  logic [DATA_W-1:0] in_vk,
    input  logic              in_qj_busy,
    input  logic              in_qk_busy,
    input  logic [TAG_W-1:0]  in_qj,
    input  logic [TAG_W-1:0]  in_qk,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [TAG_W-1:0]  in_rob,
    output logic              full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic              alu_valid,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2,
    output logic [DATA_W-1:0] alu_pc,
    output logic [DATA_W-1:0] alu_imm,
    output logic [TAG_W-1:0]  alu_rob
);

    import alu_rs_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_qj_busy;
    logic [DEPTH-1:0]  r_qk_busy;
    logic [OP_W-1:0]   r_op  [DEPTH];
    logic [DATA_W-1:0] r_vj  [DEPTH];
    logic [DATA_W-1:0] r_vk  [DEPTH];
    logic [TAG_W-1:0]  r_qj  [DEPTH];
    logic [TAG_W-1:0]  r_qk  [DEPTH];
    logic [DATA_W-1:0] r_imm [DEPTH];
    logic [DATA_W-1:0] r_pc  [DEPTH];
    logic [TAG_W-1:0]  r_rob [DEPTH];

    logic [DEPTH-1:0]  w_ready;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_free_found;
    logic [IDX_W-1:0]  w_rdy_idx;
    logic              w_rdy_found;
    logic              w_do_insert;
    logic              w_do_dispatch;
    logic              w_in_j_hit;
    logic              w_in_k_hit;
    logic [DATA_W-1:0] w_in_vj;
    logic [DATA_W-1:0] w_in_vk;

    assign w_ready = r_busy & ~r_qj_busy & ~r_qk_busy;

    rs_prio_enc #(.N(DEPTH), .IDX_W(IDX_W)) u_free_enc (
        .i_req   (~r_busy),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    rs_prio_enc #(.N(DEPTH), .IDX_W(IDX_W)) u_rdy_enc (
        .i_req   (w_ready),
        .o_idx   (w_rdy_idx),
        .o_found (w_rdy_found)
    );

    assign full          = ~w_free_found;
    assign w_do_insert   = rdy_in & ~clear_in & in_valid & w_free_found;
    assign w_do_dispatch = rdy_in & ~clear_in & w_rdy_found;

    // An operand produced on the CDB in the insert cycle is captured directly
    assign w_in_j_hit = cdb_valid & in_qj_busy & (in_qj == cdb_tag);
    assign w_in_k_hit = cdb_valid & in_qk_busy & (in_qk == cdb_tag);
    assign w_in_vj    = w_in_j_hit ? cdb_value : in_vj;
    assign w_in_vk    = w_in_k_hit ? cdb_value : in_vk;

    // Station entries: insert into the free slot, wake pending operands, retire the issued slot
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy    <= '0;
            r_qj_busy <= '0;
            r_qk_busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]  <= '0;
                r_vj[i]  <= '0;
                r_vk[i]  <= '0;
                r_qj[i]  <= '0;
                r_qk[i]  <= '0;
                r_imm[i] <= '0;
                r_pc[i]  <= '0;
                r_rob[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clear_in) begin
                r_busy <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (cdb_valid && r_busy[i] && r_qj_busy[i] && (r_qj[i] == cdb_tag)) begin
                        r_vj[i]      <= cdb_value;
                        r_qj_busy[i] <= FALSE;
                    end
                    if (cdb_valid && r_busy[i] && r_qk_busy[i] && (r_qk[i] == cdb_tag)) begin
                        r_vk[i]      <= cdb_value;
                        r_qk_busy[i] <= FALSE;
                    end
                    if (w_do_dispatch && (w_rdy_idx == IDX_W'(i))) begin
                        r_busy[i] <= FALSE;
                    end
                    // Free slot is never busy, so it cannot collide with wakeup or dispatch
                    if (w_do_insert && (w_free_idx == IDX_W'(i))) begin
                        r_busy[i]    <= TRUE;
                        r_op[i]      <= in_op;
                        r_vj[i]      <= w_in_vj;
                        r_vk[i]      <= w_in_vk;
                        r_qj_busy[i] <= in_qj_busy & ~w_in_j_hit;
                        r_qk_busy[i] <= in_qk_busy & ~w_in_k_hit;
                        r_qj[i]      <= in_qj;
                        r_qk[i]      <= in_qk;
                        r_imm[i]     <= in_imm;
                        r_pc[i]      <= in_pc;
                        r_rob[i]     <= in_rob;
                    end
                end
            end
        end
    end

    // Registered issue bundle; data holds between pulses
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            alu_valid <= FALSE;
            alu_op    <= '0;
            alu_rs1   <= '0;
            alu_rs2   <= '0;
            alu_pc    <= '0;
            alu_imm   <= '0;
            alu_rob   <= '0;
        end else if (w_do_dispatch) begin
            alu_valid <= TRUE;
            alu_op    <= r_op[w_rdy_idx];
            alu_rs1   <= r_vj[w_rdy_idx];
            alu_rs2   <= r_vk[w_rdy_idx];
            alu_pc    <= r_pc[w_rdy_idx];
            alu_imm   <= r_imm[w_rdy_idx];
            alu_rob   <= r_rob[w_rdy_idx];
        end else begin
            alu_valid <= FALSE;
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: hand-computed expectations checked with immediate assertions.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in, in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_vj, in_vk, in_imm, in_pc, cdb_value;
    logic        in_qj_busy, in_qk_busy, cdb_valid;
    logic [3:0]  in_qj, in_qk, in_rob, cdb_tag;
    logic        full, alu_valid;
    logic [5:0]  alu_op;
    logic [31:0] alu_rs1, alu_rs2, alu_pc, alu_imm;
    logic [3:0]  alu_rob;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rs #(.DEPTH(DEPTH), .OP_W(6), .DATA_W(32), .TAG_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .in_valid(in_valid), .in_op(in_op), .in_vj(in_vj), .in_vk(in_vk),
        .in_qj_busy(in_qj_busy), .in_qk_busy(in_qk_busy), .in_qj(in_qj), .in_qk(in_qk),
        .in_imm(in_imm), .in_pc(in_pc), .in_rob(in_rob), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .alu_valid(alu_valid), .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_pc(alu_pc), .alu_imm(alu_imm), .alu_rob(alu_rob)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic put(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic qjb, input logic [3:0] qj, input logic qkb,
                       input logic [3:0] qk, input logic [3:0] rob);
        in_valid = 1'b1; in_op = op; in_vj = vj; in_vk = vk;
        in_qj_busy = qjb; in_qj = qj; in_qk_busy = qkb; in_qk = qk;
        in_rob = rob; in_imm = 32'h1000 + 32'(rob); in_pc = 32'h400 + 32'(rob);
    endtask

    task automatic cdb(input logic v, input logic [3:0] tag, input logic [31:0] val);
        cdb_valid = v; cdb_tag = tag; cdb_value = val;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; in_valid = 1'b0;
        in_op = 6'd0; in_vj = 32'd0; in_vk = 32'd0; in_imm = 32'd0; in_pc = 32'd0;
        in_qj_busy = 1'b0; in_qk_busy = 1'b0; in_qj = 4'd0; in_qk = 4'd0; in_rob = 4'd0;
        cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_value = 32'd0;
        step(); step();
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_valid", 64'(alu_valid), 64'd0);
        chk("rst_rs1", 64'(alu_rs1), 64'd0);
        chk("rst_rob", 64'(alu_rob), 64'd0);
        rst_in = 1'b1;

        // ready insert: pulse after the second edge
        put(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        step(); in_valid = 1'b0;
        chk("rdy_lat", 64'(alu_valid), 64'd0);
        step();
        chk("rdy_valid", 64'(alu_valid), 64'd1);
        chk("rdy_rs1", 64'(alu_rs1), 64'd5);
        chk("rdy_rs2", 64'(alu_rs2), 64'd7);
        chk("rdy_rob", 64'(alu_rob), 64'd3);
        chk("rdy_op", 64'(alu_op), 64'(OP_ADD));
        chk("rdy_pc", 64'(alu_pc), 64'h403);
        chk("rdy_imm", 64'(alu_imm), 64'h1003);
        step();
        chk("rdy_pulse", 64'(alu_valid), 64'd0);

        // wakeup from CDB
        put(OP_SUB, 32'd0, 32'd2, 1'b1, 4'd9, 1'b0, 4'd0, 4'd5);
        step(); in_valid = 1'b0;
        step(); step();
        chk("wk_wait", 64'(alu_valid), 64'd0);
        cdb(1'b1, 4'd9, 32'h10);
        step(); cdb(1'b0, 4'd0, 32'd0);
        chk("wk_same", 64'(alu_valid), 64'd0);
        step();
        chk("wk_valid", 64'(alu_valid), 64'd1);
        chk("wk_rs1", 64'(alu_rs1), 64'h10);
        chk("wk_rs2", 64'(alu_rs2), 64'd2);
        chk("wk_rob", 64'(alu_rob), 64'd5);
        chk("wk_op", 64'(alu_op), 64'(OP_SUB));

        // bypass on insert
        put(OP_XOR, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd7);
        cdb(1'b1, 4'd4, 32'hAB);
        step(); in_valid = 1'b0; cdb(1'b0, 4'd0, 32'd0);
        chk("byp_lat", 64'(alu_valid), 64'd0);
        step();
        chk("byp_valid", 64'(alu_valid), 64'd1);
        chk("byp_rs1", 64'(alu_rs1), 64'd1);
        chk("byp_rs2", 64'(alu_rs2), 64'hAB);
        chk("byp_rob", 64'(alu_rob), 64'd7);

        // fill the station with ops waiting on tag 1
        for (int i = 0; i < DEPTH; i++) begin
            put(OP_OR, 32'd0, 32'(i), 1'b1, 4'd1, 1'b0, 4'd0, 4'(i));
            step();
        end
        chk("full_set", 64'(full), 64'd1);
        put(OP_AND, 32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
        step(); in_valid = 1'b0;
        chk("full_drop_v", 64'(alu_valid), 64'd0);
        chk("full_hold", 64'(full), 64'd1);
        cdb(1'b1, 4'd1, 32'h77);
        step(); cdb(1'b0, 4'd0, 32'd0);
        chk("full_wk", 64'(alu_valid), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("full_dv", 64'(alu_valid), 64'd1);
            chk("full_drob", 64'(alu_rob), 64'(i));
            chk("full_drs1", 64'(alu_rs1), 64'h77);
            chk("full_drs2", 64'(alu_rs2), 64'(i));
            if (i == 0) chk("full_drop", 64'(full), 64'd0);
        end
        step();
        chk("full_end", 64'(alu_valid), 64'd0);

        // flush with a concurrent insert and wakeup
        for (int i = 0; i < 4; i++) begin
            put(OP_SLT, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'(i + 1));
            step();
        end
        put(OP_ADD, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
        clear_in = 1'b1; cdb(1'b1, 4'd2, 32'h22);
        step(); clear_in = 1'b0; in_valid = 1'b0; cdb(1'b0, 4'd0, 32'd0);
        chk("clr_valid", 64'(alu_valid), 64'd0);
        chk("clr_full", 64'(full), 64'd0);
        chk("clr_busy", 64'(dut.r_busy), 64'd0);
        step();
        chk("clr_nodisp", 64'(alu_valid), 64'd0);
        cdb(1'b1, 4'd2, 32'h22);
        step(); cdb(1'b0, 4'd0, 32'd0);
        step();
        chk("clr_nowk", 64'(alu_valid), 64'd0);
        put(OP_BNE, 32'd4, 32'd6, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
        step(); in_valid = 1'b0;
        chk("clr_e0_busy", 64'(dut.r_busy), 64'h01);
        chk("clr_e0_rob", 64'(dut.r_rob[0]), 64'd6);
        step();
        chk("clr_ins_v", 64'(alu_valid), 64'd1);
        chk("clr_ins_rob", 64'(alu_rob), 64'd6);

        // rdy_in low: nothing applied
        rdy_in = 1'b0;
        put(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        step();
        chk("stall_v0", 64'(alu_valid), 64'd0);
        step(); in_valid = 1'b0;
        chk("stall_busy", 64'(dut.r_busy), 64'd0);
        rdy_in = 1'b1;
        step();
        chk("stall_v1", 64'(alu_valid), 64'd0);

        // asynchronous reset while entries are pending and a pulse is out
        for (int i = 0; i < 3; i++) begin
            put(OP_SRA, 32'd0, 32'd0, 1'b1, 4'd3, 1'b0, 4'd0, 4'(i + 1));
            step();
        end
        put(OP_ADD, 32'h55, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
        step(); in_valid = 1'b0;
        step();
        chk("ar_pre_v", 64'(alu_valid), 64'd1);
        chk("ar_pre_rob", 64'(alu_rob), 64'd10);
        #2 rst_in = 1'b0;
        #1;
        chk("ar_valid", 64'(alu_valid), 64'd0);
        chk("ar_rob", 64'(alu_rob), 64'd0);
        chk("ar_rs1", 64'(alu_rs1), 64'd0);
        chk("ar_full", 64'(full), 64'd0);
        chk("ar_busy", 64'(dut.r_busy), 64'd0);
        step(); rst_in = 1'b1;
        cdb(1'b1, 4'd3, 32'h33);
        step(); cdb(1'b0, 4'd0, 32'd0);
        chk("ar_post0", 64'(alu_valid), 64'd0);
        step();
        chk("ar_post1", 64'(alu_valid), 64'd0);
        step();
        chk("ar_post2", 64'(alu_valid), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
